// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared widths, state encoding and partial-sum decode for the CIM readout scheduler
// Contents:
//   PSUM_W, ACT_W   partial-sum and activation widths
//   sched_state_e   scheduler FSM states
//   decode_psum     5-bit partial sum -> 4-bit signed activation
package cim_pkg;

  localparam int PSUM_W = 5;
  localparam int ACT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sched_state_e;

  // Weighted bit sum 5*b4 + 4*b3 + 3*b2 + 2*b1 + b0 peaks at 15, so it fits in
  // 4 bits unsigned; subtracting 8 modulo 16 yields the two's complement result.
  function automatic logic [ACT_W-1:0] decode_psum(input logic [PSUM_W-1:0] p);
    logic [ACT_W-1:0] s;
    s = (p[4] ? 4'd5 : 4'd0) + (p[3] ? 4'd4 : 4'd0) + (p[2] ? 4'd3 : 4'd0)
      + (p[1] ? 4'd2 : 4'd0) + {3'd0, p[0]};
    return s - 4'd8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with external priority pointer
// Ports:
//   req    in   N   request vector
//   ptr    in   IW  highest-priority index (must be < N)
//   gnt    out  N   one-hot grant, zero when no request
//   idx    out  IW  index of the granted requester
//   valid  out  1   any request granted
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from ptr upward, wrapping; the first requester found wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/cim_readout_sched.sv
// rtl/cim_readout_sched.sv - round-robin burst readout of CIM macros through one shared decode lane group
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, macro_mask  round start pulse and set of macros to serve
//   busy, done         round in progress, one-cycle completion pulse
//   mac_req/gnt/data   per-macro beat handshake and packed 5-bit partial sums
//   out_*              registered decoded beat stream with valid/ready
module cim_readout_sched
  import cim_pkg::*;
#(
  parameter int MACRO_NUM   = 4,
  parameter int CHANNEL_NUM = 128,
  parameter int LANES       = 16,
  localparam int BEATS      = CHANNEL_NUM / LANES,
  localparam int MW         = (MACRO_NUM > 1) ? $clog2(MACRO_NUM) : 1,
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [MACRO_NUM-1:0]                macro_mask,
  output logic                                busy,
  output logic                                done,
  input  logic [MACRO_NUM-1:0]                mac_req,
  output logic [MACRO_NUM-1:0]                mac_gnt,
  input  logic [MACRO_NUM*LANES*PSUM_W-1:0]   mac_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*ACT_W-1:0]              out_data,
  output logic [MW-1:0]                       out_macro,
  output logic [BW-1:0]                       out_beat,
  output logic                                out_last
);

  sched_state_e state, state_nx;

  logic [MACRO_NUM-1:0]       pending;
  logic [MACRO_NUM-1:0]       pend_after;
  logic [MACRO_NUM-1:0]       lock_mask;
  logic [MACRO_NUM-1:0]       req_eff;
  logic [MACRO_NUM-1:0]       arb_gnt;
  logic [MW-1:0]              rr_ptr;
  logic [MW-1:0]              lock_idx;
  logic [MW-1:0]              win_idx;
  logic                       locked;
  logic                       arb_valid;
  logic                       can_accept;
  logic                       xfer;
  logic                       beat_last;
  logic [BW-1:0]              beat_cnt;
  logic [LANES*PSUM_W-1:0]    sel_psum;
  logic [LANES*ACT_W-1:0]     dec_data;

  // The output register can take a new beat when empty or draining this cycle.
  // The same condition lets FLUSH retire once the last beat has left.
  assign can_accept = !out_valid || out_ready;

  // While a burst is locked only the owning macro may compete.
  always_comb begin
    lock_mask = '1;
    if (locked) begin
      lock_mask = '0;
      lock_mask[lock_idx] = 1'b1;
    end
  end

  assign req_eff = mac_req & pending & lock_mask;

  rr_arbiter #(.N(MACRO_NUM), .IW(MW)) u_arb (
    .req   (req_eff),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (win_idx),
    .valid (arb_valid)
  );

  always_comb begin
    mac_gnt = '0;
    if (state == RUN && can_accept && arb_valid) mac_gnt = arb_gnt;
  end

  assign xfer       = |mac_gnt;
  assign beat_last  = (beat_cnt == BW'(BEATS - 1));
  assign pend_after = pending & ~mac_gnt;
  assign busy       = (state != IDLE);

  always_comb begin
    sel_psum = '0;
    for (int m = 0; m < MACRO_NUM; m++) begin
      if (win_idx == MW'(m)) sel_psum = mac_data[m*LANES*PSUM_W +: LANES*PSUM_W];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign dec_data[l*ACT_W +: ACT_W] = decode_psum(sel_psum[l*PSUM_W +: PSUM_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (macro_mask == '0) ? FLUSH : RUN;
      end
      RUN: begin
        if (xfer && beat_last && pend_after == '0) state_nx = FLUSH;
      end
      FLUSH: begin
        if (can_accept) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      pending   <= '0;
      rr_ptr    <= '0;
      locked    <= 1'b0;
      lock_idx  <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_macro <= '0;
      out_beat  <= '0;
      out_last  <= 1'b0;
    end else begin
      // done is registered so it is high during the first IDLE cycle.
      done <= (state == FLUSH) && can_accept;

      if (state == IDLE && start) begin
        pending  <= macro_mask;
        locked   <= 1'b0;
        beat_cnt <= '0;
      end else if (xfer) begin
        if (beat_last) begin
          pending  <= pend_after;
          locked   <= 1'b0;
          beat_cnt <= '0;
          rr_ptr   <= (win_idx == MW'(MACRO_NUM - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          locked   <= 1'b1;
          lock_idx <= win_idx;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= dec_data;
        out_macro <= win_idx;
        out_beat  <= beat_cnt;
        out_last  <= beat_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cim_readout_sched.sv
// tb/tb_cim_readout_sched.sv - scoreboard bench for cim_readout_sched
module tb_cim_readout_sched;

  localparam int MN    = 4;
  localparam int CN    = 128;
  localparam int LN    = 16;
  localparam int BEATS = CN / LN;
  localparam int MW    = 2;
  localparam int BW    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [MN-1:0]         macro_mask = '0;
  logic                  busy, done;
  logic [MN-1:0]         mac_req = '0;
  logic [MN-1:0]         mac_gnt;
  logic [MN*LN*5-1:0]    mac_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [LN*4-1:0]       out_data;
  logic [MW-1:0]         out_macro;
  logic [BW-1:0]         out_beat;
  logic                  out_last;

  cim_readout_sched #(.MACRO_NUM(MN), .CHANNEL_NUM(CN), .LANES(LN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .macro_mask (macro_mask),
    .busy       (busy),
    .done       (done),
    .mac_req    (mac_req),
    .mac_gnt    (mac_gnt),
    .mac_data   (mac_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_macro  (out_macro),
    .out_beat   (out_beat),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    int          mac;
    int          beat;
    logic        last;
  } exp_t;
  exp_t sbq[$];

  // macro source model: each macro streams values from its own running counter
  int mcnt[MN];
  int salt = 0;

  // reference scheduler model
  int            m_state = 0;
  logic [MN-1:0] m_pend = '0;
  int            m_rr = 0;
  int            m_lock = -1;
  int            m_beat = 0;
  logic          m_ov = 1'b0;
  logic          m_done = 1'b0;

  int   beats_out = 0;
  int   cyc = 0;
  int   dut_rc[MN];
  logic hold_v = 1'b0;
  logic [63:0] hold_d;
  int   hold_b, hold_m;

  // stimulus knobs
  int            rdy_from = -1, rdy_len = 0;
  int            drop_mac = -1, drop_after = 0, drop_left = 0;
  int            restart_cyc = -1;
  logic [MN-1:0] req_en = '1;

  function automatic logic [4:0] psum(input int m, input int c, input int l);
    return 5'((salt + m*11 + c + l*3) % 32);
  endfunction

  function automatic logic [3:0] ref_dec(input logic [4:0] p);
    int v;
    v = 5*int'(p[4]) + 4*int'(p[3]) + 3*int'(p[2]) + 2*int'(p[1]) + int'(p[0]) - 8;
    return 4'(v);
  endfunction

  task automatic build_data();
    for (int m = 0; m < MN; m++)
      for (int l = 0; l < LN; l++)
        mac_data[(m*LN+l)*5 +: 5] = psum(m, mcnt[m], l);
  endtask

  task automatic step();
    int            w;
    int            nstate;
    logic          can, n_ov, n_done;
    logic [MN-1:0] exp_g;
    logic [MN-1:0] xv;
    logic [63:0]   d;
    exp_t          e;
    @(negedge clk);
    check("busy", busy, m_state != 0);
    check("done", done, m_done);
    check("valid", out_valid, m_ov);
    if (hold_v) begin
      check("hold_data", out_data, hold_d);
      check("hold_beat", out_beat, 64'(hold_b));
      check("hold_macro", out_macro, 64'(hold_m));
    end
    if (m_ov && out_ready) begin
      if (sbq.size() == 0) check("sb_underflow", out_valid, 1'b0);
      else begin
        e = sbq.pop_front();
        check("data", out_data, e.data);
        check("macro", out_macro, 64'(e.mac));
        check("beat", out_beat, 64'(e.beat));
        check("last", out_last, e.last);
        beats_out++;
      end
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data; hold_b = int'(out_beat); hold_m = int'(out_macro);
    if (drop_mac >= 0 && !mac_req[drop_mac]) check("lock_hold", mac_gnt, '0);
    for (int m = 0; m < MN; m++) if (mac_gnt[m] && mac_req[m]) dut_rc[m]++;

    can = !m_ov || out_ready;
    w = -1;
    if (m_state == 1 && can) begin
      if (m_lock >= 0) begin
        if (mac_req[m_lock] && m_pend[m_lock]) w = m_lock;
      end else begin
        for (int k = 0; k < MN; k++) begin
          int c;
          c = (m_rr + k) % MN;
          if (w < 0 && mac_req[c] && m_pend[c]) w = c;
        end
      end
    end
    exp_g = '0;
    if (w >= 0) exp_g[w] = 1'b1;
    check("gnt", mac_gnt, exp_g);

    nstate = m_state; n_ov = m_ov; n_done = 1'b0; xv = '0;
    if (w >= 0) begin
      d = '0;
      for (int l = 0; l < LN; l++) d[l*4 +: 4] = ref_dec(psum(w, mcnt[w], l));
      e.data = d; e.mac = w; e.beat = m_beat; e.last = (m_beat == BEATS-1);
      sbq.push_back(e);
      xv[w] = 1'b1;
      n_ov = 1'b1;
      if (m_beat == BEATS-1) begin
        m_lock = -1; m_pend[w] = 1'b0; m_rr = (w + 1) % MN; m_beat = 0;
        if (m_pend == '0) nstate = 2;
      end else begin
        m_lock = w; m_beat++;
      end
    end else if (out_ready) n_ov = 1'b0;
    if (m_state == 0 && start) begin
      m_pend = macro_mask; m_lock = -1; m_beat = 0;
      nstate = (macro_mask == '0) ? 2 : 1;
    end else if (m_state == 2 && can) begin
      nstate = 0; n_done = 1'b1;
    end
    m_ov = n_ov; m_done = n_done; m_state = nstate;

    @(posedge clk);
    #1;
    for (int m = 0; m < MN; m++) if (xv[m]) mcnt[m]++;
    build_data();
    cyc++;
    start = 1'b0;
    if (cyc == restart_cyc) begin start = 1'b1; macro_mask = 4'b1110; end
    out_ready = !(rdy_from >= 0 && cyc >= rdy_from && cyc < rdy_from + rdy_len);
    mac_req = req_en;
    if (drop_mac >= 0) begin
      if (dut_rc[drop_mac] == drop_after && drop_left > 0) begin
        mac_req[drop_mac] = 1'b0; drop_left--;
      end
    end
  endtask

  task automatic run_round(input logic [MN-1:0] mask, input int exp_beats);
    macro_mask = mask;
    start = 1'b1;
    beats_out = 0;
    cyc = 0;
    for (int m = 0; m < MN; m++) dut_rc[m] = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (m_state == 0) break;
    end
    check("round_end_busy", busy, 1'b0);
    step();
    check("beats", 64'(beats_out), 64'(exp_beats));
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, out_valid, 1'b0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_gnt"}, mac_gnt, '0);
    check({pfx, "_data"}, out_data, '0);
    check({pfx, "_macro"}, out_macro, '0);
    check({pfx, "_beat"}, out_beat, '0);
    check({pfx, "_last"}, out_last, 1'b0);
  endtask

  initial begin
    for (int m = 0; m < MN; m++) begin mcnt[m] = 0; dut_rc[m] = 0; end
    build_data();
    #3;
    check_zero("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mac_req = req_en;

    // decode sweep: four single-macro rounds walk lane 0 of macro 0 through all 32 codes
    for (int r = 0; r < 4; r++) run_round(4'b0001, BEATS);

    // round robin, all macros, no backpressure
    run_round(4'b1111, 4*BEATS);

    // backpressure mid-burst
    rdy_from = 6; rdy_len = 5;
    run_round(4'b0010, BEATS);
    rdy_from = -1;

    // lock: macro 2 drops req after four beats while macro 3 is requesting
    drop_mac = 2; drop_after = 4; drop_left = 6;
    run_round(4'b1100, 2*BEATS);
    drop_mac = -1;

    // masking
    run_round(4'b0101, 2*BEATS);
    check("mask_m1", 64'(dut_rc[1]), 0);
    check("mask_m3", 64'(dut_rc[3]), 0);
    check("mask_m0", 64'(dut_rc[0]), 64'(BEATS));

    // empty mask: done without any grant
    run_round(4'b0000, 0);

    // start while running is ignored
    restart_cyc = 3;
    run_round(4'b0001, BEATS);
    restart_cyc = -1;

    // async reset after beat 5 of macro 0
    macro_mask = 4'b1111;
    start = 1'b1;
    cyc = 0;
    for (int m = 0; m < MN; m++) dut_rc[m] = 0;
    for (int i = 0; i < 100 && dut_rc[0] < 6; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    m_state = 0; m_pend = '0; m_rr = 0; m_lock = -1; m_beat = 0;
    m_ov = 1'b0; m_done = 1'b0; hold_v = 1'b0;
    sbq.delete();
    rst_n = 1'b1;
    run_round(4'b0001, BEATS);
    check("rst_full_m0", 64'(dut_rc[0]), 64'(BEATS));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
